// File: rtl/alt_sequence_generator.sv
// Transmit side of the alternating-sequence link: emits 00,01,10 / 11,01,10
// sequences in strict alternation under a valid/ready handshake.
module alt_sequence_generator #(
  parameter int GAP = 0,
  parameter int CW  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          ready,
  output logic [1:0]    x1_x0,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, GAPW} state_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP);

  state_t        state, state_nxt;
  logic          parity;
  logic [CW-1:0] remaining;
  logic [3:0]    gap_cnt;
  logic          launch;
  logic          seq_done;
  logic          last_seq;

  assign last_seq = (remaining == CW'(1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    seq_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          state_nxt = S0;
          launch    = 1'b1;
        end
      end
      S0: if (ready) state_nxt = S1;
      S1: if (ready) state_nxt = S2;
      S2: begin
        if (ready) begin
          seq_done = 1'b1;
          if (last_seq)      state_nxt = IDLE;
          else if (GAP == 0) state_nxt = S0;
          else               state_nxt = GAPW;
        end
      end
      GAPW: if (gap_cnt <= 4'd1) state_nxt = S0;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; 01 is the idle filler symbol.
  always_comb begin
    valid = (state == S0) || (state == S1) || (state == S2);
    busy  = (state != IDLE);
    x1_x0 = 2'b01;
    if (state == S0)      x1_x0 = {parity, parity};
    else if (state == S2) x1_x0 = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity    <= 1'b0;
      remaining <= '0;
      sent      <= '0;
      done      <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      done <= seq_done && last_seq;
      if (launch) remaining <= len;
      if (seq_done) begin
        sent      <= sent + CW'(1);
        parity    <= ~parity;
        remaining <= remaining - CW'(1);
        gap_cnt   <= GAP_INIT;
      end else if (state == GAPW) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule
